// File: rtl/fsm.sv
// Two-state Moore machine (A/B). A low input toggles the state on every
// clock, a high input freezes it. The output is decoded from the registered
// state only, so it can only change right after a rising clock edge.
module fsm #(
  parameter bit RESET_STATE = 1'b1  // 0 = enter A on reset, 1 = enter B on reset
) (
  input  logic clk,
  input  logic areset,  // synchronous, active-high despite the name
  input  logic in,
  output logic out_fsm
);

  typedef enum logic [0:0] {
    ST_A = 1'b0,
    ST_B = 1'b1
  } state_t;

  localparam state_t RESET_ST = RESET_STATE ? ST_B : ST_A;

  state_t state_q;
  state_t state_d;

  // Next-state logic: toggle on in=0, hold on in=1; anything unencoded goes to B.
  always_comb begin
    state_d = ST_B;
    case (state_q)
      ST_A:    state_d = in ? ST_A : ST_B;
      ST_B:    state_d = in ? ST_B : ST_A;
      default: state_d = ST_B;
    endcase
  end

  // State register; reset is only looked at on the clock edge and wins over in.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= RESET_ST;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output straight from the flop, no path from in.
  always_comb begin
    out_fsm = (state_q == ST_B);
  end

endmodule

// File: tb/tb_fsm.sv
// Directed bench for fsm: a vector table run against both reset-state
// variants, followed by hand-written sequences for reset timing, input
// glitches and a model-tracked pseudo-random run.
module tb_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset;
  logic in_sig;
  logic out1;  // RESET_STATE = 1 (default)
  logic out0;  // RESET_STATE = 0

  fsm dut (
    .clk    (clk),
    .areset (areset),
    .in     (in_sig),
    .out_fsm(out1)
  );

  fsm #(.RESET_STATE(1'b0)) dut0 (
    .clk    (clk),
    .areset (areset),
    .in     (in_sig),
    .out_fsm(out0)
  );

  typedef struct {
    logic rst;
    logic inp;
    logic exp1;
    logic exp0;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs[NVEC];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, sample 1ns later.
  task automatic step(input logic r, input logic i);
    @(negedge clk);
    areset = r;
    in_sig = i;
    @(posedge clk);
    #1;
  endtask

  logic m1, m0;
  logic r_rand, i_rand;

  initial begin
    areset = 1'b0;
    in_sig = 1'b0;

    //          rst   in    out1  out0
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0};  // power-up reset
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1};  // toggle
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0};  // hold x3
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};  // hold x3 on the other state
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1};  // one-cycle pulse skips a toggle
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0};  // mid-run reset, in=1 ignored
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1};  // toggling resumes
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b0};  // reset, in=0 ignored
    vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b0};  // reset held
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1};

    for (int k = 0; k < NVEC; k++) begin
      step(vecs[k].rst, vecs[k].inp);
      $display("vec %0d: rst=%b in=%b out1=%b (exp %b) out0=%b (exp %b)",
               k, vecs[k].rst, vecs[k].inp, out1, vecs[k].exp1, out0, vecs[k].exp0);
      check($sformatf("vec%0d_out1", k), out1, vecs[k].exp1);
      check($sformatf("vec%0d_out0", k), out0, vecs[k].exp0);
    end

    // State now: dut=A (0), dut0=B (1). Hold once.
    step(1'b0, 1'b1);
    $display("hold: out1=%b out0=%b", out1, out0);
    check("hold_out1", out1, 1'b0);
    check("hold_out0", out0, 1'b1);

    // Reset pulse entirely between edges with in=1: nothing may change.
    @(negedge clk);
    in_sig = 1'b1;
    #2 areset = 1'b1;
    #1;
    check("async_mid_out1", out1, 1'b0);
    check("async_mid_out0", out0, 1'b1);
    #1 areset = 1'b0;
    @(posedge clk);
    #1;
    $display("between-edge reset pulse (in=1): out1=%b out0=%b", out1, out0);
    check("async_hold_out1", out1, 1'b0);
    check("async_hold_out0", out0, 1'b1);

    // Same pulse with in=0: the edge must see a normal toggle, not a reset.
    @(negedge clk);
    in_sig = 1'b0;
    #2 areset = 1'b1;
    #1;
    check("async_mid2_out1", out1, 1'b0);
    #1 areset = 1'b0;
    @(posedge clk);
    #1;
    $display("between-edge reset pulse (in=0): out1=%b out0=%b", out1, out0);
    check("async_tog_out1", out1, 1'b1);
    check("async_tog_out0", out0, 1'b0);

    // Glitching in between edges must not reach the output.
    @(negedge clk);
    in_sig = 1'b1;
    #1 in_sig = 1'b0;
    #1;
    check("in_glitch_out1", out1, 1'b1);
    check("in_glitch_out0", out0, 1'b0);
    #1 in_sig = 1'b1;
    @(posedge clk);
    #1;
    $display("in glitch then in=1 at edge: out1=%b out0=%b", out1, out0);
    check("in_glitch_edge_out1", out1, 1'b1);
    check("in_glitch_edge_out0", out0, 1'b0);

    // Pseudo-random run against a reference model, checked every edge.
    m1 = 1'b1;
    m0 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      r_rand = ($urandom_range(0, 7) == 0);
      i_rand = 1'($urandom_range(0, 1));
      if (r_rand) begin
        m1 = 1'b1;
        m0 = 1'b0;
      end else if (!i_rand) begin
        m1 = ~m1;
        m0 = ~m0;
      end
      step(r_rand, i_rand);
      $display("rand %0d: rst=%b in=%b out1=%b (exp %b) out0=%b (exp %b)",
               k, r_rand, i_rand, out1, m1, out0, m0);
      check($sformatf("rand%0d_out1", k), out1, m1);
      check($sformatf("rand%0d_out0", k), out0, m0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm.md
FSM -- requirements
Module: fsm

Interface
REQ-001 The parameter RESET_STATE SHALL default to 1 (state B) and SHALL select the state entered on reset: 0 = A, 1 = B.
REQ-002 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock, with all state changes on its rising edge.
REQ-003 The port areset SHALL be an input, 1 bit wide, and SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 The port in SHALL be an input, 1 bit wide, carrying the FSM input sampled on the rising edge of clk.
REQ-005 The port out_fsm SHALL be an output, 1 bit wide, and SHALL be the Moore output decoded from the current state only.

Function
REQ-006 The block SHALL be a two-state Moore machine with states A and B, one bit of state register.
REQ-007 out_fsm SHALL be 0 in state A and 1 in state B.
REQ-008 out_fsm SHALL be a function of the registered state only, with no combinational path from in to out_fsm.
REQ-009 The transitions from state B SHALL be: in=0 -> A; in=1 -> B (hold).
REQ-010 The transitions from state A SHALL be: in=0 -> B; in=1 -> A (hold).
REQ-011 The resulting behaviour SHALL be: in=0 toggles the state on every clock, and in=1 freezes the state.
REQ-012 Latency SHALL be one cycle: a value of in sampled at rising edge N SHALL be reflected on out_fsm immediately after edge N, and SHALL be stable until edge N+1.
REQ-013 No glitch on out_fsm SHALL occur between rising edges.
REQ-014 Any illegal or unencoded state value (for example X after power-up before reset) SHALL be recovered to B on the next edge where areset=0, or to RESET_STATE on the next edge where areset=1.
REQ-015 areset SHALL have priority over in: if areset=1 at a rising edge, the next state SHALL be RESET_STATE regardless of in.
REQ-016 The state register SHALL NOT react to areset between clock edges (no asynchronous path).

Reset
REQ-017 With areset=1 sampled at a rising edge, the state SHALL become RESET_STATE, giving out_fsm=1 with the default parameter, after that edge.
REQ-018 When reset is asserted mid-operation, regardless of the current state, the state SHALL go to RESET_STATE on the first rising edge where areset=1.
REQ-019 Normal transitions SHALL resume on the first rising edge where areset=0.
REQ-020 Before the first reset edge, out_fsm SHALL be unspecified.

Verification
REQ-021 Power-up reset: areset=1 for one edge, in=0 -> out_fsm=1 after that edge, then with areset=0 and in=0, out_fsm SHALL toggle 0,1,0,1 on successive edges.
REQ-022 Hold: with the state at B, hold in=1 for 3 edges -> out_fsm SHALL stay 1; with the state at A, hold in=1 for 3 edges -> out_fsm SHALL stay 0.
REQ-023 Single-cycle pulse: with in=0 toggling and a one-cycle in=1 pulse inserted -> the toggle sequence SHALL skip exactly one transition (for example 1,0,0,1), and the state SHALL be checked against a reference model each edge.
REQ-024 Mid-run reset: with the state at A (out_fsm=0), assert areset=1 for one edge with in=1 -> out_fsm=1 after the edge, and toggling SHALL resume next edge with in=0.
REQ-025 Synchronous-reset check: a pulse on areset that rises and falls between two rising edges SHALL have no effect on out_fsm.
REQ-026 Parameter check: with RESET_STATE=0, reset -> out_fsm=0, and all transitions SHALL otherwise be identical.
